// File: rtl/ir_drive_commander_pkg.sv
// Shared types for the IR drive commander: drive modes, NEC key codes,
// the status byte layout and the proximity-nibble mapping.
package ir_drive_pkg;

    typedef enum logic [2:0] {
        ModeStop  = 3'd0,
        ModeFwd   = 3'd1,
        ModeLeft  = 3'd2,
        ModeBrake = 3'd3,
        ModeRight = 3'd4,
        ModeRev   = 3'd5
    } drive_mode_t;

    localparam logic [7:0] CMD_STOP   = 8'h00;
    localparam logic [7:0] CMD_SPD_DN = 8'h01;
    localparam logic [7:0] CMD_FWD    = 8'h02;
    localparam logic [7:0] CMD_SPD_UP = 8'h03;
    localparam logic [7:0] CMD_LEFT   = 8'h04;
    localparam logic [7:0] CMD_BRAKE  = 8'h05;
    localparam logic [7:0] CMD_RIGHT  = 8'h06;
    localparam logic [7:0] CMD_REV    = 8'h08;

    typedef struct packed {
        logic [3:0] prox;
        logic [2:0] mode;
        logic       marker;
    } status_byte_t;

    function automatic logic [3:0] prox_nibble(input logic [7:0] prox);
        if (prox > 8'd63) begin
            return 4'hF;
        end else if (prox < 8'd4) begin
            return 4'h0;
        end else begin
            return prox[5:2];
        end
    endfunction

    function automatic logic is_drive_mode(input drive_mode_t m);
        case (m)
            ModeFwd, ModeLeft, ModeRight, ModeRev: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ir_drive_commander_status_tx_scheduler.sv
// Status byte launcher: periodic trigger counter, one coalescing pending bit,
// and valid/ready holding toward uart_tx.
module status_tx_scheduler #(
    parameter int unsigned TELEM_PERIOD = 5_000_000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       mode_change_i,
    input  logic [7:0] status_i,
    input  logic       tx_ready_i,
    output logic       tx_valid_o,
    output logic [7:0] tx_data_o
);

    localparam int unsigned PerW = (TELEM_PERIOD > 1) ? $clog2(TELEM_PERIOD) : 1;
    localparam logic [PerW-1:0] PerLast = PerW'(TELEM_PERIOD - 1);
    localparam logic [PerW-1:0] PerOne  = PerW'(1);

    logic [PerW-1:0] period_q, period_d;
    logic            period_wrap;
    logic            trigger;
    logic            valid_q, valid_d;
    logic            pending_q, pending_d;
    logic [7:0]      data_q, data_d;

    always_comb begin
        period_wrap = (period_q == PerLast);
        period_d    = period_wrap ? '0 : period_q + PerOne;
        trigger     = mode_change_i | period_wrap;

        valid_d   = valid_q;
        data_d    = data_q;
        pending_d = pending_q;
        if (valid_q) begin
            if (tx_ready_i) begin
                valid_d = 1'b0;
            end
            if (trigger) begin
                pending_d = 1'b1;
            end
        end else if (trigger || pending_q) begin
            // Launch samples the live status, so a pending byte reflects current state.
            valid_d   = 1'b1;
            data_d    = status_i;
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            period_q  <= '0;
            valid_q   <= 1'b0;
            pending_q <= 1'b0;
            data_q    <= 8'h00;
        end else begin
            period_q  <= period_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
            data_q    <= data_d;
        end
    end

    assign tx_valid_o = valid_q;
    assign tx_data_o  = data_q;

endmodule

// File: rtl/ir_drive_commander.sv
// NEC frame validation, key-to-drive-mode mapping, dead-man brake and status streaming.
// Define IRCMD_RAMP_EN to ramp the duty outputs toward the target instead of stepping.
module ir_drive_commander
    import ir_drive_pkg::*;
#(
    parameter int unsigned DUTY_W         = 7,
    parameter int unsigned DUTY_INIT      = 20,
    parameter int unsigned DUTY_STEP      = 4,
    parameter int unsigned DUTY_MAX       = 100,
    parameter int unsigned TIMEOUT_CYCLES = 6_000_000,
    parameter int unsigned TELEM_PERIOD   = 5_000_000,
    parameter int unsigned ADDR_CHECK     = 1,
    parameter logic [15:0] EXP_ADDR       = 16'h6B86,
    parameter int unsigned RAMP_PERIOD    = 50_000
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              frame_valid_i,
    input  logic [31:0]       frame_i,
    input  logic [7:0]        prox_i,
    output logic [2:0]        mode_o,
    output logic [DUTY_W-1:0] duty1_o,
    output logic [DUTY_W-1:0] duty2_o,
    output logic              timeout_flag_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic [7:0]        tx_data_o
);

    localparam int unsigned DW1 = DUTY_W + 1;
    localparam logic [DUTY_W:0]   StepExt  = DW1'(DUTY_STEP);
    localparam logic [DUTY_W:0]   MaxExt   = DW1'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] DutyInit = DUTY_W'(DUTY_INIT);
    localparam int unsigned DmW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DmW-1:0] DmLast = DmW'(TIMEOUT_CYCLES - 1);
    localparam logic [DmW-1:0] DmOne  = DmW'(1);

    drive_mode_t       mode_q, mode_d, key_mode;
    logic [DmW-1:0]    dm_q, dm_d;
    logic              timeout_q, timeout_d;
    logic [DUTY_W-1:0] target_q, target_d;
    logic [DUTY_W:0]   duty_ext, duty_up, duty_dn;
    logic [7:0]        cmd;
    logic              addr_ok, accept;
    logic              key_is_mode, key_is_drive, spd_up, spd_dn;
    logic              mode_change;
    status_byte_t      status;

    assign cmd     = frame_i[23:16];
    assign addr_ok = (ADDR_CHECK == 0) || (frame_i[15:0] == EXP_ADDR);
    assign accept  = frame_valid_i && (frame_i[31:24] == ~cmd) && addr_ok;

    always_comb begin
        key_mode    = ModeStop;
        key_is_mode = 1'b0;
        spd_up      = 1'b0;
        spd_dn      = 1'b0;
        case (cmd)
            CMD_STOP:   begin key_mode = ModeStop;  key_is_mode = 1'b1; end
            CMD_FWD:    begin key_mode = ModeFwd;   key_is_mode = 1'b1; end
            CMD_LEFT:   begin key_mode = ModeLeft;  key_is_mode = 1'b1; end
            CMD_BRAKE:  begin key_mode = ModeBrake; key_is_mode = 1'b1; end
            CMD_RIGHT:  begin key_mode = ModeRight; key_is_mode = 1'b1; end
            CMD_REV:    begin key_mode = ModeRev;   key_is_mode = 1'b1; end
            CMD_SPD_UP: spd_up = 1'b1;
            CMD_SPD_DN: spd_dn = 1'b1;
            default:    ;
        endcase
        key_is_drive = key_is_mode && is_drive_mode(key_mode);
    end

    always_comb begin
        duty_ext = {1'b0, target_q};
        duty_up  = duty_ext + StepExt;
        if (duty_up > MaxExt) begin
            duty_up = MaxExt;
        end
        duty_dn = (duty_ext < StepExt) ? '0 : duty_ext - StepExt;
        if (duty_dn > MaxExt) begin
            duty_dn = MaxExt;
        end
    end

    always_comb begin
        mode_d    = mode_q;
        dm_d      = dm_q;
        timeout_d = timeout_q;
        target_d  = target_q;

        if (accept && spd_up) begin
            target_d = duty_up[DUTY_W-1:0];
        end else if (accept && spd_dn) begin
            target_d = duty_dn[DUTY_W-1:0];
        end
        if (accept && key_is_mode) begin
            mode_d = key_mode;
        end
        if (accept && key_is_drive) begin
            timeout_d = 1'b0;
        end

        if (!is_drive_mode(mode_q)) begin
            dm_d = '0;
        end else if (accept && key_is_drive) begin
            dm_d = '0;
        end else if (dm_q == DmLast) begin
            dm_d = '0;
            // A mode key landing on the expiry cycle takes precedence over the brake.
            if (!(accept && key_is_mode)) begin
                mode_d    = ModeBrake;
                timeout_d = 1'b1;
            end
        end else begin
            dm_d = dm_q + DmOne;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mode_q    <= ModeStop;
            dm_q      <= '0;
            timeout_q <= 1'b0;
            target_q  <= DutyInit;
        end else begin
            mode_q    <= mode_d;
            dm_q      <= dm_d;
            timeout_q <= timeout_d;
            target_q  <= target_d;
        end
    end

    assign mode_change = (mode_d != mode_q);

    always_comb begin
        status.prox   = prox_nibble(prox_i);
        status.mode   = mode_d;
        status.marker = 1'b1;
    end

    status_tx_scheduler #(
        .TELEM_PERIOD (TELEM_PERIOD)
    ) u_status_tx (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .mode_change_i (mode_change),
        .status_i      (status),
        .tx_ready_i    (tx_ready_i),
        .tx_valid_o    (tx_valid_o),
        .tx_data_o     (tx_data_o)
    );

`ifdef IRCMD_RAMP_EN
    localparam int unsigned RampW = (RAMP_PERIOD > 1) ? $clog2(RAMP_PERIOD) : 1;
    localparam logic [RampW-1:0] RampLast = RampW'(RAMP_PERIOD - 1);
    localparam logic [RampW-1:0] RampOne  = RampW'(1);
    localparam logic [DUTY_W-1:0] DutyOne = DUTY_W'(1);

    logic [RampW-1:0]  ramp_q, ramp_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              ramp_tick, snap;

    always_comb begin
        ramp_tick = (ramp_q == RampLast);
        ramp_d    = ramp_tick ? '0 : ramp_q + RampOne;
        snap      = mode_change && ((mode_d == ModeStop) || (mode_d == ModeBrake));
        duty_d    = duty_q;
        if (snap) begin
            duty_d = target_d;
        end else if (ramp_tick) begin
            if (duty_q < target_q) begin
                duty_d = duty_q + DutyOne;
            end else if (duty_q > target_q) begin
                duty_d = duty_q - DutyOne;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ramp_q <= '0;
            duty_q <= DutyInit;
        end else begin
            ramp_q <= ramp_d;
            duty_q <= duty_d;
        end
    end

    assign duty1_o = duty_q;
    assign duty2_o = duty_q;
`else
    logic unused_ramp_cfg;
    assign unused_ramp_cfg = ^RAMP_PERIOD;

    assign duty1_o = target_q;
    assign duty2_o = target_q;
`endif

    assign mode_o         = mode_q;
    assign timeout_flag_o = timeout_q;

endmodule

// File: tb/tb_ir_drive_commander.sv
// Directed bench for ir_drive_commander with a queue-based status byte scoreboard.
module tb_ir_drive_commander;

    localparam logic [31:0] F_FWD   = 32'hFD02_6B86;
    localparam logic [31:0] F_LEFT  = 32'hFB04_6B86;
    localparam logic [31:0] F_BRAKE = 32'hFA05_6B86;
    localparam logic [31:0] F_RIGHT = 32'hF906_6B86;
    localparam logic [31:0] F_REV   = 32'hF708_6B86;
    localparam logic [31:0] F_STOP  = 32'hFF00_6B86;
    localparam logic [31:0] F_UP    = 32'hFC03_6B86;
    localparam logic [31:0] F_DN    = 32'hFE01_6B86;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_valid = 1'b0;
    logic [31:0] frame = 32'h0;
    logic [7:0]  prox = 8'h00;
    logic [2:0]  mode;
    logic [6:0]  duty1, duty2;
    logic        timeout_flag;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic [7:0]  tx_data;

    int tests = 0;
    int fails = 0;
    int rx_count = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    ir_drive_commander #(
        .DUTY_W         (7),
        .DUTY_INIT      (20),
        .DUTY_STEP      (4),
        .DUTY_MAX       (100),
        .TIMEOUT_CYCLES (100),
        .TELEM_PERIOD   (1000),
        .ADDR_CHECK     (1),
        .EXP_ADDR       (16'h6B86),
        .RAMP_PERIOD    (50)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .frame_valid_i  (frame_valid),
        .frame_i        (frame),
        .prox_i         (prox),
        .mode_o         (mode),
        .duty1_o        (duty1),
        .duty2_o        (duty2),
        .timeout_flag_o (timeout_flag),
        .tx_valid_o     (tx_valid),
        .tx_ready_i     (tx_ready),
        .tx_data_o      (tx_data)
    );

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: every cycle tx_valid is high the byte must match the queue head.
    always @(negedge clk) begin
        #2;
        if (!reset && tx_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL tx_unexpected: got byte 0x%0h, expected none", tx_data);
            end else begin
                check("tx_data", int'(tx_data), int'(exp_q[0]));
                if (tx_ready) begin
                    void'(exp_q.pop_front());
                    rx_count++;
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        frame_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rx_count = 0;
    endtask

    task automatic send(input logic [31:0] f);
        frame = f;
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] mode_frames[6];
        int          mode_vals[6];
        logic [7:0]  prox_vals[7];
        logic [3:0]  prox_nibs[7];
        int          exp_duty;

        mode_frames = '{F_FWD, F_LEFT, F_RIGHT, F_REV, F_BRAKE, F_STOP};
        mode_vals   = '{1, 2, 4, 5, 3, 0};
        prox_vals   = '{8'hFF, 8'h02, 8'h14, 8'h40, 8'h3F, 8'h04, 8'h03};
        prox_nibs   = '{4'hF, 4'h0, 4'h5, 4'hF, 4'hF, 4'h1, 4'h0};

        @(negedge clk);

        // Reset state, key map and rejected frames
        do_reset();
        check("reset_mode", mode, 0);
        check("reset_duty1", duty1, 20);
        check("reset_duty2", duty2, 20);
        check("reset_timeout", timeout_flag, 0);
        check("reset_tx_valid", tx_valid, 0);
        check("reset_tx_data", tx_data, 0);

        exp_q.push_back(8'h03);
        send(F_FWD);
        check("fwd_mode", mode, 1);
        check("fwd_tx_valid", tx_valid, 1);
        drain("fwd_drain");
        for (int i = 1; i < 6; i++) begin
            exp_q.push_back(8'(mode_vals[i] * 2 + 1));
            send(mode_frames[i]);
            check("keymap_mode", mode, mode_vals[i]);
            drain("keymap_drain");
        end
        send(32'hFD02_0000);
        check("bad_addr_mode", mode, 0);
        send(32'hFC02_6B86);
        check("bad_inv_mode", mode, 0);
        send(32'hF807_6B86);
        check("unknown_cmd_mode", mode, 0);
        repeat (5) @(negedge clk);
        check("rejected_no_tx", rx_count, 6);

        // Dead-man timeout and refresh by repeats
        do_reset();
        exp_q.push_back(8'h03);
        send(F_FWD);
        repeat (99) @(negedge clk);
        check("pre_timeout_mode", mode, 1);
        check("pre_timeout_flag", timeout_flag, 0);
        exp_q.push_back(8'h07);
        @(negedge clk);
        check("timeout_mode", mode, 3);
        check("timeout_flag", timeout_flag, 1);
        drain("timeout_drain");
        exp_q.push_back(8'h03);
        send(F_FWD);
        check("refwd_flag_clear", timeout_flag, 0);
        for (int i = 0; i < 6; i++) begin
            repeat (49) @(negedge clk);
            send(F_FWD);
        end
        repeat (60) @(negedge clk);
        check("repeat_no_brake", mode, 1);
        check("repeat_no_flag", timeout_flag, 0);
        exp_q.push_back(8'h01);
        send(F_STOP);
        drain("repeat_drain");

        // Duty saturation both ways
        do_reset();
        exp_duty = 20;
        for (int i = 0; i < 30; i++) begin
            send(F_UP);
            exp_duty = (exp_duty + 4 > 100) ? 100 : exp_duty + 4;
            check("duty_up", duty1, exp_duty);
        end
        check("duty_up_sat1", duty1, 100);
        check("duty_up_sat2", duty2, 100);
        for (int i = 0; i < 30; i++) begin
            send(F_DN);
            exp_duty = (exp_duty < 4) ? 0 : exp_duty - 4;
            check("duty_dn", duty2, exp_duty);
        end
        check("duty_dn_sat1", duty1, 0);
        check("duty_dn_mode", mode, 0);

        // Backpressure: three mode changes, one held byte plus one pending byte
        do_reset();
        tx_ready = 1'b0;
        exp_q.push_back(8'h03);
        exp_q.push_back(8'h09);
        send(F_FWD);
        send(F_LEFT);
        send(F_RIGHT);
        repeat (47) @(negedge clk);
        check("stall_valid", tx_valid, 1);
        tx_ready = 1'b1;
        drain("stall_drain");
        repeat (20) @(negedge clk);
        check("stall_byte_count", rx_count, 2);

        // Proximity nibble in the status byte
        do_reset();
        for (int i = 0; i < 7; i++) begin
            prox = prox_vals[i];
            exp_q.push_back({prox_nibs[i], (i % 2 == 0) ? 3'd1 : 3'd0, 1'b1});
            send((i % 2 == 0) ? F_FWD : F_STOP);
            drain("prox_drain");
        end
        prox = 8'h00;

        // Periodic byte exactly TELEM_PERIOD cycles after reset
        do_reset();
        repeat (999) @(negedge clk);
        check("telem_early", tx_valid, 0);
        exp_q.push_back(8'h01);
        @(negedge clk);
        check("telem_period", tx_valid, 1);
        drain("telem_drain");

        // Reset abandons a held byte
        do_reset();
        tx_ready = 1'b0;
        exp_q.push_back(8'h03);
        send(F_FWD);
        check("held_valid", tx_valid, 1);
        do_reset();
        check("abandon_valid", tx_valid, 0);
        check("abandon_data", tx_data, 0);
        check("abandon_mode", mode, 0);
        tx_ready = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
